uni_stream_cnt: RTL and testbench

Unipolar stochastic-stream-to-binary converter. It counts the 1s in a unipolar bitstream over a fixed window of 2^WIDTH accepted samples and reports the exact count as a binary value with a one-cycle valid pulse. It sits directly downstream of the bipolar-to-unipolar conversion stage in the stream datapath. It closes the loop from bitstream back to binary for result readout and for checking in the bench.

---
 rtl/uni_stream_cnt_pkg.sv | 10 +
 rtl/uni_stream_cnt.sv | 88 ++++++++
 tb/tb_uni_stream_cnt.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uni_stream_cnt_pkg.sv
// Shared stream-readout package: state encoding for the bitstream-to-binary
// counter stages.
package uni_stream_cnt_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cnt_state_e;

endpackage : uni_stream_cnt_pkg

// File: rtl/uni_stream_cnt.sv
// Unipolar stochastic-stream-to-binary converter: counts the 1s over a window
// of 2^WIDTH accepted samples and reports the exact count with a valid pulse.
module uni_stream_cnt
    import uni_stream_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH:0]   out
);

    localparam int unsigned CNT_W = WIDTH + 1;

    cnt_state_e             state;
    cnt_state_e             state_nxt;
    logic [CNT_W-1:0]       ones_cnt;
    logic [WIDTH-1:0]       smp_cnt;
    logic [CNT_W-1:0]       ones_sum;
    logic                   last_smp;

    // Next-state and completion decode
    always_comb begin
        state_nxt = state;
        last_smp  = 1'b0;
        ones_sum  = ones_cnt + CNT_W'(in);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (in_valid && (smp_cnt == '1)) begin
                    last_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, counters and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ones_cnt  <= '0;
            smp_cnt   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    ones_cnt <= '0;
                    smp_cnt  <= '0;
                end
                RUN: begin
                    if (in_valid) begin
                        ones_cnt <= ones_sum;
                        smp_cnt  <= smp_cnt + WIDTH'(1);
                    end
                    // Include the final sample directly so the result needs no extra cycle
                    if (last_smp) begin
                        out       <= ones_sum;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    ones_cnt <= '0;
                    smp_cnt  <= '0;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy = (state == RUN);
    end

endmodule : uni_stream_cnt

// File: tb/tb_uni_stream_cnt.sv
// Self-checking bench for uni_stream_cnt (WIDTH=3): directed window scenarios
// plus randomized traffic against a queue-based window model.
module tb_uni_stream_cnt;

    localparam int unsigned W  = 3;
    localparam int unsigned NS = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic         in_bit;
    logic         busy;
    logic         out_valid;
    logic [W:0]   out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_ov    = 0;
    int last_out = -1;
    int ov_cyc  = -1;
    int st_cyc  = 0;

    // Reference model: accepted samples of the current window kept in a queue
    bit m_busy;
    bit q[$];
    int m_out;
    bit m_ov;

    uni_stream_cnt #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in       (in_bit),
        .busy     (busy),
        .out_valid(out_valid),
        .out      (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qsum();
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        q.delete();
        m_out  = 0;
        m_ov   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare outputs
    task automatic cycle(input bit s, input bit v, input bit b, input string tag);
        start    = s;
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        cyc++;
        m_ov = 1'b0;
        if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1;
                q.delete();
            end
        end else if (v) begin
            q.push_back(b);
            if (q.size() == NS) begin
                m_out  = qsum();
                m_ov   = 1'b1;
                m_busy = 1'b0;
            end
        end
        #1;
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "_ovld"}, 32'(out_valid), 32'(m_ov));
        chk({tag, "_out"},  32'(out), 32'(m_out));
        if (out_valid === 1'b1) begin
            n_ov++;
            last_out = int'(out);
            ov_cyc   = cyc;
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic begin_test();
        n_ov     = 0;
        last_out = -1;
        ov_cyc   = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        model_reset();
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovld", 32'(out_valid), 32'd0);
        chk("rst_out",  32'(out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(2, "pre");

        // T1: all ones, latency and busy in pulse cycle
        begin_test();
        st_cyc = cyc + 1;
        cycle(1'b1, 1'b0, 1'b0, "t1s");
        for (int i = 0; i < int'(NS); i++) cycle(1'b0, 1'b1, 1'b1, "t1");
        chk("t1_busy_in_pulse", 32'(busy), 32'd0);
        chk("t1_val", 32'(last_out), 32'd8);
        chk("t1_latency", 32'(ov_cyc + 1 - st_cyc), 32'(NS + 1));
        idle_cycles(3, "t1i");
        chk("t1_out_hold", 32'(out), 32'd8);
        chk("t1_npulse", 32'(n_ov), 32'd1);

        // T2: all zeros, then alternating 1,0
        begin_test();
        cycle(1'b1, 1'b0, 1'b0, "t2s");
        for (int i = 0; i < int'(NS); i++) cycle(1'b0, 1'b1, 1'b0, "t2a");
        chk("t2_zero", 32'(last_out), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, "t2s2");
        for (int i = 0; i < int'(NS); i++) cycle(1'b0, 1'b1, 1'(i % 2 == 0), "t2b");
        chk("t2_half", 32'(last_out), 32'd4);
        chk("t2_npulse", 32'(n_ov), 32'd2);

        // T3: in_valid gaps carrying in=1 must not count
        begin_test();
        begin
            int k = 0;
            cycle(1'b1, 1'b0, 1'b0, "t3s");
            for (int i = 0; i < 12; i++) begin
                if (i % 3 == 2) begin
                    cycle(1'b0, 1'b0, 1'b1, "t3");
                end else begin
                    cycle(1'b0, 1'b1, 1'(k % 3 != 1), "t3");
                    k++;
                end
            end
        end
        chk("t3_val", 32'(last_out), 32'd5);
        chk("t3_npulse", 32'(n_ov), 32'd1);

        // T4: start re-pulsed mid-window is ignored
        begin_test();
        cycle(1'b1, 1'b0, 1'b0, "t4s");
        for (int i = 0; i < int'(NS); i++)
            cycle(1'(i == 2 || i == 5), 1'b1, 1'(i < 3), "t4");
        chk("t4_val", 32'(last_out), 32'd3);
        chk("t4_pulse_pos", 32'(ov_cyc), 32'(cyc));
        idle_cycles(NS + 2, "t4i");
        chk("t4_npulse", 32'(n_ov), 32'd1);

        // T5: reset mid-window discards the partial count
        begin_test();
        cycle(1'b1, 1'b0, 1'b0, "t5s");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, "t5a");
        rst = 1'b1;
        #2;
        model_reset();
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ovld", 32'(out_valid), 32'd0);
        chk("t5_rst_out",  32'(out), 32'd0);
        @(posedge clk); cyc++; #1;
        rst = 1'b0;
        idle_cycles(2, "t5i");
        chk("t5_nopulse", 32'(n_ov), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, "t5s2");
        for (int i = 0; i < int'(NS); i++) cycle(1'b0, 1'b1, 1'b1, "t5b");
        chk("t5_val", 32'(last_out), 32'd8);

        // T6: start held high, back-to-back all-ones windows
        begin_test();
        for (int i = 0; i < 4 * int'(NS + 1); i++) cycle(1'b1, 1'b1, 1'b1, "t6");
        chk("t6_npulse", 32'(n_ov), 32'd4);
        chk("t6_val", 32'(last_out), 32'd8);
        idle_cycles(NS + 2, "t6i");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(3) == 0), 1'($urandom_range(3) != 0), 1'($urandom), "rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uni_stream_cnt
